sobel_frame_seq: RTL
====================

SOBEL_FRAME_SEQ -- requirements
Module: sobel_frame_seq

Interface
REQ-001 Parameter MIN_DIM, default 3: smallest legal image width/height.
REQ-002 Parameter MAX_WIDTH, default 1920: largest legal width.
REQ-003 Parameter MAX_HEIGHT, default 1080: largest legal height.
REQ-004 Parameter WDOG_CYCLES, default 4096: stall limit in cycles (used only with SOBEL_WDOG_EN).
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 reset_n  in  1  synchronous, active-low reset.
REQ-007 start  in  1  level request to process one frame.
REQ-008 abort  in  1  cancel current frame.
REQ-009 image_width  in  11  frame width in pixels.
REQ-010 image_height  in  11  frame height in pixels.
REQ-011 buffer_full  in  1  line buffer primed.
REQ-012 valid_px  in  1  threshold stage produced one output pixel.
REQ-013 thr_done  in  1  threshold stage finished frame.
REQ-014 enable_lb  out  1  line-buffer enable.
REQ-015 enable_conv  out  1  convolution enable.
REQ-016 total_pixel  out  21  latched width*height.
REQ-017 pixel_count  out  21  output pixels counted this frame.
REQ-018 busy  out  1  frame in progress.
REQ-019 done  out  1  one-cycle frame-complete pulse.
REQ-020 err_code  out  2  00 none, 01 bad dimension, 10 watchdog timeout, 11 count mismatch.

Function
REQ-021 FSM states SHALL be IDLE, CHECK, FILL, RUN, DONE, ERR; all outputs registered.
REQ-022 IDLE: on start=1, latch image_width/image_height, clear pixel_count, go CHECK next cycle; busy=0.
REQ-023 CHECK (1 cycle): width or height outside [MIN_DIM, MAX_*] -> ERR with err_code=01; else total_pixel=width*height (21-bit, no overflow possible in legal range) -> FILL.
REQ-024 FILL: enable_lb=1, enable_conv=0; buffer_full=1 -> RUN.
REQ-025 RUN: enable_lb=1, enable_conv=1; each valid_px cycle increments pixel_count, saturating at total_pixel.
REQ-026 RUN with thr_done=1: pixel_count (including a same-cycle valid_px) equal to total_pixel -> DONE; otherwise -> ERR with err_code=11.
REQ-027 DONE: done=1 for exactly one cycle, enables 0, then IDLE; pixel_count and total_pixel held until next start.
REQ-028 ERR: enables 0, busy=0, err_code held; leave to IDLE only when start=0; err_code cleared on next accepted start.
REQ-029 busy=1 in CHECK, FILL, RUN; start asserted while busy SHALL be ignored; input dimension changes while busy SHALL be ignored.
REQ-030 abort=1 in CHECK/FILL/RUN -> IDLE next cycle, enables 0, no done pulse, err_code unchanged; abort wins over simultaneous thr_done or buffer_full.
REQ-031 enable_lb/enable_conv SHALL change only on the cycle following the state transition causing them.

Reset
REQ-032 reset_n=0 at a clock edge SHALL force IDLE, enable_lb=0, enable_conv=0, busy=0, done=0, err_code=00, total_pixel=0, pixel_count=0, including mid-frame.

Configuration
REQ-033 With SOBEL_WDOG_EN defined: in FILL/RUN a counter cleared on state entry and on every valid_px or buffer_full cycle SHALL, upon reaching WDOG_CYCLES, force ERR with err_code=10.
REQ-034 Without SOBEL_WDOG_EN: no watchdog logic, err_code=10 never produced, WDOG_CYCLES unused.

Structure
REQ-035 Package sobel_pkg SHALL hold the state enum, err_code constants and default dimension limits.
REQ-036 Watchdog SHALL be sub-module sobel_wdog (clear, tick, expired), instantiated only under SOBEL_WDOG_EN.

Verification
REQ-037 8x4 frame: start, buffer_full after 20 cycles, 32 valid_px, thr_done with 32nd -> done pulse once, pixel_count=32, err_code=00.
REQ-038 width=2, height=10 -> ERR in 2 cycles, err_code=01, enables never asserted; drop start -> IDLE.
REQ-039 8x4 frame, thr_done after 31 valid_px -> ERR, err_code=11, no done.
REQ-040 abort in RUN at pixel 10 -> IDLE next cycle, enables 0, no done; new start runs cleanly.
REQ-041 SOBEL_WDOG_EN, WDOG_CYCLES=16, no valid_px for 16 cycles in RUN -> err_code=10; without macro -> remains in RUN.
REQ-042 reset_n=0 mid-RUN -> all outputs at reset values next cycle; start ignored while busy.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel frame sequencer.
// State encoding, error codes and default image dimension limits.
package sobel_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CHECK = 3'd1,
      ST_FILL  = 3'd2,
      ST_RUN   = 3'd3,
      ST_DONE  = 3'd4,
      ST_ERR   = 3'd5
   } state_t;

   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_DIM  = 2'b01;
   localparam logic [1:0] ERR_WDOG = 2'b10;
   localparam logic [1:0] ERR_CNT  = 2'b11;

   localparam int DEF_MIN_DIM     = 3;
   localparam int DEF_MAX_WIDTH   = 1920;
   localparam int DEF_MAX_HEIGHT  = 1080;
   localparam int DEF_WDOG_CYCLES = 4096;

   localparam int DIM_W = 11;
   localparam int PIX_W = 21;

   function automatic logic dim_ok(input logic [DIM_W-1:0] d,
                                   input logic [DIM_W-1:0] lo,
                                   input logic [DIM_W-1:0] hi);
      return (d >= lo) && (d <= hi);
   endfunction

endpackage

// File: rtl/sobel_wdog.sv
// Stall watchdog for the Sobel frame sequencer.
// Down-counter reloaded on clear; expired flags the CYCLES-th consecutive
// tick cycle without a clear. Only built when SOBEL_WDOG_EN is defined.
module sobel_wdog
   import sobel_pkg::*;
#(
   parameter int CYCLES = DEF_WDOG_CYCLES
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic tick,
   output logic expired
);

   localparam int CNT_W = $clog2(CYCLES + 1);
   localparam logic [CNT_W-1:0] LOAD = CNT_W'(CYCLES - 1);

   logic [CNT_W-1:0] r_remain;

   // reload on clear, otherwise count stalled cycles down to terminal count
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_remain <= LOAD;
      end else if (clear) begin
         r_remain <= LOAD;
      end else if (tick && (r_remain != '0)) begin
         r_remain <= r_remain - CNT_W'(1);
      end
   end

   assign expired = tick && !clear && (r_remain == '0);

endmodule

// File: rtl/sobel_frame_seq.sv
// Sobel frame sequencer: validates frame dimensions, sequences line-buffer
// fill and convolution, counts output pixels and reports completion/errors.
// Optional stall watchdog enabled by defining SOBEL_WDOG_EN.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; dimensions latched on start
// CHECK | one cycle dimension range check, total_pixel computed
// FILL  | line buffer priming (enable_lb)
// RUN   | convolution active, valid_px counted until thr_done
// DONE  | one-cycle done pulse
// ERR   | err_code held, waits for start to drop
module sobel_frame_seq
   import sobel_pkg::*;
#(
   parameter int MIN_DIM     = DEF_MIN_DIM,
   parameter int MAX_WIDTH   = DEF_MAX_WIDTH,
   parameter int MAX_HEIGHT  = DEF_MAX_HEIGHT,
   parameter int WDOG_CYCLES = DEF_WDOG_CYCLES
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             abort,
   input  logic [DIM_W-1:0] image_width,
   input  logic [DIM_W-1:0] image_height,
   input  logic             buffer_full,
   input  logic             valid_px,
   input  logic             thr_done,
   output logic             enable_lb,
   output logic             enable_conv,
   output logic [PIX_W-1:0] total_pixel,
   output logic [PIX_W-1:0] pixel_count,
   output logic             busy,
   output logic             done,
   output logic [1:0]       err_code
);

   localparam logic [DIM_W-1:0] LP_MIN  = DIM_W'(MIN_DIM);
   localparam logic [DIM_W-1:0] LP_MAXW = DIM_W'(MAX_WIDTH);
   localparam logic [DIM_W-1:0] LP_MAXH = DIM_W'(MAX_HEIGHT);

   state_t           r_state, w_next;
   logic [DIM_W-1:0] r_width, r_height, w_width_next, w_height_next;
   logic [PIX_W-1:0] r_total, r_count, w_total_next, w_count_next;
   logic [PIX_W-1:0] w_product, w_count_inc;
   logic [1:0]       r_err, w_err_next;
   logic             r_enable_lb, r_enable_conv, r_busy, r_done;
   logic             w_dims_ok, w_wd_expired;

   // legal range bounds width*height below 2^21, so the truncated product is exact
   assign w_product   = PIX_W'(r_width) * PIX_W'(r_height);
   assign w_dims_ok   = dim_ok(r_width, LP_MIN, LP_MAXW) && dim_ok(r_height, LP_MIN, LP_MAXH);
   assign w_count_inc = (valid_px && (r_count < r_total)) ? r_count + PIX_W'(1) : r_count;

`ifdef SOBEL_WDOG_EN
   logic w_wd_tick, w_wd_clear;

   assign w_wd_tick  = (r_state == ST_FILL) || (r_state == ST_RUN);
   assign w_wd_clear = !w_wd_tick || valid_px || buffer_full;

   sobel_wdog #(
      .CYCLES (WDOG_CYCLES)
   ) u_wdog (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (w_wd_clear),
      .tick    (w_wd_tick),
      .expired (w_wd_expired)
   );
`else
   // watchdog compiled out: expiry is constant low for any legal WDOG_CYCLES
   assign w_wd_expired = (WDOG_CYCLES < 0);
`endif

   // state register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // next-state and next-datapath decode; abort has top priority while busy
   always_comb begin
      w_next        = r_state;
      w_width_next  = r_width;
      w_height_next = r_height;
      w_total_next  = r_total;
      w_count_next  = r_count;
      w_err_next    = r_err;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_next        = ST_CHECK;
               w_width_next  = image_width;
               w_height_next = image_height;
               w_total_next  = '0;
               w_count_next  = '0;
               w_err_next    = ERR_NONE;
            end
         end
         ST_CHECK: begin
            if (abort) begin
               w_next = ST_IDLE;
            end else if (!w_dims_ok) begin
               w_next     = ST_ERR;
               w_err_next = ERR_DIM;
            end else begin
               w_next       = ST_FILL;
               w_total_next = w_product;
            end
         end
         ST_FILL: begin
            if (abort) begin
               w_next = ST_IDLE;
            end else if (buffer_full) begin
               w_next = ST_RUN;
            end else if (w_wd_expired) begin
               w_next     = ST_ERR;
               w_err_next = ERR_WDOG;
            end
         end
         ST_RUN: begin
            if (abort) begin
               w_next = ST_IDLE;
            end else begin
               w_count_next = w_count_inc;
               if (thr_done) begin
                  if (w_count_inc == r_total) begin
                     w_next = ST_DONE;
                  end else begin
                     w_next     = ST_ERR;
                     w_err_next = ERR_CNT;
                  end
               end else if (w_wd_expired) begin
                  w_next     = ST_ERR;
                  w_err_next = ERR_WDOG;
               end
            end
         end
         ST_DONE: begin
            w_next = ST_IDLE;
         end
         ST_ERR: begin
            if (!start) begin
               w_next = ST_IDLE;
            end
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   // datapath and output registers, outputs decoded from the next state
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_width       <= '0;
         r_height      <= '0;
         r_total       <= '0;
         r_count       <= '0;
         r_err         <= ERR_NONE;
         r_enable_lb   <= 1'b0;
         r_enable_conv <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
      end else begin
         r_width       <= w_width_next;
         r_height      <= w_height_next;
         r_total       <= w_total_next;
         r_count       <= w_count_next;
         r_err         <= w_err_next;
         r_enable_lb   <= (w_next == ST_FILL) || (w_next == ST_RUN);
         r_enable_conv <= (w_next == ST_RUN);
         r_busy        <= (w_next == ST_CHECK) || (w_next == ST_FILL) || (w_next == ST_RUN);
         r_done        <= (w_next == ST_DONE);
      end
   end

   assign enable_lb   = r_enable_lb;
   assign enable_conv = r_enable_conv;
   assign total_pixel = r_total;
   assign pixel_count = r_count;
   assign busy        = r_busy;
   assign done        = r_done;
   assign err_code    = r_err;

endmodule
